// File: rtl/pc_pkg.sv
// Shared constants for the PC pipeline: reset PC, NOP bubble PC, fetch step.
package pc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0100_0000;
  localparam logic [31:0] BUBBLE_PC_DEFAULT = 32'h0000_0073;
  localparam int unsigned PC_INCR           = 4;

endpackage

// File: rtl/pc_stage_reg.sv
// One pipeline slot: PC plus valid flag with hold, bubble and load behaviour.
// Priority is reset, then bubble, then hold, then load.
module pc_stage_reg #(
  parameter int             XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] BUBBLE_PC  = '0,
  parameter bit             RESET_VALID = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            hold,
  input  logic            bubble,
  input  logic [XLEN-1:0] d_pc,
  input  logic            d_valid,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  // Slot register: squash to the bubble PC, keep the current value, or load.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      valid <= RESET_VALID;
    end else if (bubble) begin
      pc    <= BUBBLE_PC;
      valid <= 1'b0;
    end else if (!hold) begin
      pc    <= d_pc;
      valid <= d_valid;
    end
  end

endmodule

// File: rtl/pc_pipeline.sv
// PC pipeline: fetch PC generation plus NSTAGES registered PC/valid slots
// with redirect (squash young stages) and stall (hold front, insert bubble).
module pc_pipeline
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NSTAGES     = 5,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT),
  parameter int              KILL_DEPTH  = 2,
  parameter int              STALL_STAGE = 1,
  parameter logic [XLEN-1:0] BUBBLE_PC   = XLEN'(BUBBLE_PC_DEFAULT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [XLEN-1:0]         redirect_target,
  input  logic                    stall,
  output logic [NSTAGES*XLEN-1:0] pc_out,
  output logic [NSTAGES-1:0]      valid_out,
  output logic [15:0]             redirect_cnt
);

  // Elaboration-time parameter legality checks.
  if (NSTAGES < 2 || NSTAGES > 8) begin : g_bad_nstages
    $error("pc_pipeline: NSTAGES must be within 2..8");
  end
  if (KILL_DEPTH < 1 || KILL_DEPTH > NSTAGES - 1) begin : g_bad_kill_depth
    $error("pc_pipeline: KILL_DEPTH must be within 1..NSTAGES-1");
  end
  if (STALL_STAGE < 0 || STALL_STAGE > NSTAGES - 2) begin : g_bad_stall_stage
    $error("pc_pipeline: STALL_STAGE must be within 0..NSTAGES-2");
  end
  if (XLEN < 3) begin : g_bad_xlen
    $error("pc_pipeline: XLEN must be at least 3");
  end

  logic [XLEN-1:0]    stage_pc   [NSTAGES];
  logic [XLEN-1:0]    stage_d_pc [NSTAGES];
  logic [NSTAGES-1:0] stage_valid;
  logic [NSTAGES-1:0] stage_d_valid;
  logic [NSTAGES-1:0] stage_hold;
  logic [NSTAGES-1:0] stage_bubble;
  logic [15:0]        redirect_cnt_reg;

  // Redirect targets are word aligned; the low two bits are dropped.
  logic unused_target_bits;
  assign unused_target_bits = ^redirect_target[1:0];

  for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_fetch
      // Fetch: redirect wins over stall; otherwise step by one instruction.
      assign stage_d_pc[gi]    = redirect ? {redirect_target[XLEN-1:2], 2'b00}
                                          : stage_pc[gi] + XLEN'(PC_INCR);
      assign stage_d_valid[gi] = 1'b1;
      assign stage_hold[gi]    = stall & ~redirect;
      assign stage_bubble[gi]  = 1'b0;
    end else begin : g_later
      localparam bit KILLED   = (gi <= KILL_DEPTH);
      localparam bit HELD     = (gi <= STALL_STAGE);
      localparam bit BUB_SLOT = (gi == STALL_STAGE + 1);
      assign stage_d_pc[gi]    = stage_pc[gi-1];
      assign stage_d_valid[gi] = stage_valid[gi-1];
      assign stage_hold[gi]    = ~redirect & stall & HELD;
      assign stage_bubble[gi]  = (redirect & KILLED) | (~redirect & stall & BUB_SLOT);
    end

    pc_stage_reg #(
      .XLEN        (XLEN),
      .RESET_PC    (RESET_PC),
      .BUBBLE_PC   (BUBBLE_PC),
      .RESET_VALID (gi == 0)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .hold    (stage_hold[gi]),
      .bubble  (stage_bubble[gi]),
      .d_pc    (stage_d_pc[gi]),
      .d_valid (stage_d_valid[gi]),
      .pc      (stage_pc[gi]),
      .valid   (stage_valid[gi])
    );

    assign pc_out[gi*XLEN +: XLEN] = stage_pc[gi];
  end

  // Saturating count of accepted redirects.
  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_cnt_reg <= 16'h0000;
    end else if (redirect && redirect_cnt_reg != 16'hFFFF) begin
      redirect_cnt_reg <= redirect_cnt_reg + 16'h0001;
    end
  end

  assign valid_out    = stage_valid;
  assign redirect_cnt = redirect_cnt_reg;

endmodule

// File: tb/tb_pc_pipeline.sv
// Randomized bench for pc_pipeline against an array-based model of the stage rules.
module tb_pc_pipeline;

  localparam int          XLEN = 32;
  localparam int          NS   = 5;
  localparam int          KD   = 2;
  localparam int          SS   = 1;
  localparam logic [31:0] RPC  = 32'h0100_0000;
  localparam logic [31:0] BPC  = 32'h0000_0073;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 redirect = 1'b0;
  logic [XLEN-1:0]      redirect_target = '0;
  logic                 stall = 1'b0;
  logic [NS*XLEN-1:0]   pc_out;
  logic [NS-1:0]        valid_out;
  logic [15:0]          redirect_cnt;

  always #5 clock = ~clock;

  pc_pipeline #(
    .XLEN(XLEN), .NSTAGES(NS), .RESET_PC(RPC),
    .KILL_DEPTH(KD), .STALL_STAGE(SS), .BUBBLE_PC(BPC)
  ) dut (
    .clock(clock), .reset(reset), .redirect(redirect),
    .redirect_target(redirect_target), .stall(stall),
    .pc_out(pc_out), .valid_out(valid_out), .redirect_cnt(redirect_cnt)
  );

  // Model state
  logic [31:0] m_pc [NS];
  logic        m_val [NS];
  logic [15:0] m_cnt;
  bit          chk_en = 0;
  int          compared = 0;
  int          mismatched = 0;

  logic [NS*XLEN-1:0] exp_pc;
  logic [NS-1:0]      exp_val;

  // Per-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < NS; k++) begin
        exp_pc[k*XLEN +: XLEN] = m_pc[k];
        exp_val[k] = m_val[k];
      end
      compared++;
      if (pc_out !== exp_pc) begin
        mismatched++;
        $display("FAIL pc_out: got %h expected %h", pc_out, exp_pc);
      end
      compared++;
      if (valid_out !== exp_val) begin
        mismatched++;
        $display("FAIL valid_out: got %b expected %b", valid_out, exp_val);
      end
      compared++;
      if (redirect_cnt !== m_cnt) begin
        mismatched++;
        $display("FAIL redirect_cnt: got %h expected %h", redirect_cnt, m_cnt);
      end
    end
  end

  task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stg(input int k);
    return pc_out[k*XLEN +: XLEN];
  endfunction

  // Model of one clock edge, applied from the stage rules
  task automatic model_edge(input logic r, input logic rd, input logic [31:0] tgt, input logic st);
    logic [31:0] n_pc [NS];
    logic        n_val [NS];
    if (r) begin
      for (int k = 0; k < NS; k++) begin
        n_pc[k] = RPC;
        n_val[k] = (k == 0);
      end
      m_cnt = 16'h0;
    end else begin
      for (int k = 1; k < NS; k++) begin
        n_pc[k] = m_pc[k-1];
        n_val[k] = m_val[k-1];
      end
      n_pc[0] = m_pc[0] + 32'd4;
      n_val[0] = 1'b1;
      if (rd) begin
        n_pc[0] = tgt & 32'hFFFF_FFFC;
        for (int k = 1; k <= KD; k++) begin
          n_pc[k] = BPC;
          n_val[k] = 1'b0;
        end
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (st) begin
        for (int k = 0; k <= SS; k++) begin
          n_pc[k] = m_pc[k];
          n_val[k] = m_val[k];
        end
        n_pc[SS+1] = BPC;
        n_val[SS+1] = 1'b0;
      end
    end
    for (int k = 0; k < NS; k++) begin
      m_pc[k] = n_pc[k];
      m_val[k] = n_val[k];
    end
  endtask

  // Drive one cycle of inputs, advance the model, settle just after the edge
  task automatic step(input logic r, input logic rd, input logic [31:0] tgt, input logic st);
    @(negedge clock);
    reset = r;
    redirect = rd;
    redirect_target = tgt;
    stall = st;
    @(posedge clock);
    model_edge(r, rd, tgt, st);
    chk_en = 1;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  logic [15:0] cnt_before;

  initial begin
    // Reset for three cycles, then run six
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    check_lit("reset_f", 64'(stg(0)), 64'(RPC));
    check_lit("reset_w", 64'(stg(4)), 64'(RPC));
    check_lit("reset_valid", 64'(valid_out), 64'(5'b00001));
    check_lit("reset_cnt", 64'(redirect_cnt), 64'h0);
    run(1);
    check_lit("first_f", 64'(stg(0)), 64'h0100_0004);
    check_lit("first_d", 64'(stg(1)), 64'h0100_0000);
    check_lit("first_dvalid", 64'(valid_out[1]), 64'h1);
    run(5);
    check_lit("run6_f", 64'(stg(0)), 64'h0100_0018);
    check_lit("run6_w", 64'(stg(4)), 64'h0100_0008);
    check_lit("run6_valid", 64'(valid_out), 64'(5'b11111));

    // Redirect to an unaligned target
    step(1'b0, 1'b1, 32'h0100_0103, 1'b0);
    check_lit("redir_f", 64'(stg(0)), 64'h0100_0100);
    check_lit("redir_d", 64'(stg(1)), 64'(BPC));
    check_lit("redir_e", 64'(stg(2)), 64'(BPC));
    check_lit("redir_m", 64'(stg(3)), 64'h0100_0010);
    check_lit("redir_w", 64'(stg(4)), 64'h0100_000C);
    check_lit("redir_valid", 64'(valid_out), 64'(5'b11001));
    check_lit("redir_cnt", 64'(redirect_cnt), 64'h1);

    // Two-cycle stall with F at 0x01000010
    step(1'b1, 1'b0, 32'h0, 1'b0);
    run(4);
    check_lit("pre_stall_f", 64'(stg(0)), 64'h0100_0010);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check_lit("stall_f", 64'(stg(0)), 64'h0100_0010);
      check_lit("stall_d", 64'(stg(1)), 64'h0100_000C);
      check_lit("stall_e", 64'(stg(2)), 64'(BPC));
      check_lit("stall_evalid", 64'(valid_out[2]), 64'h0);
    end
    run(1);
    check_lit("post_stall_f", 64'(stg(0)), 64'h0100_0014);
    check_lit("post_stall_valid", 64'(valid_out), 64'(5'b00111));
    run(3);

    // Redirect and stall together: redirect wins
    cnt_before = redirect_cnt;
    step(1'b0, 1'b1, 32'h0200_0000, 1'b1);
    check_lit("both_f", 64'(stg(0)), 64'h0200_0000);
    check_lit("both_cnt", 64'(redirect_cnt), 64'(cnt_before + 16'd1));

    // Fetch PC wrap-around
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run(1);
    check_lit("wrap_f", 64'(stg(0)), 64'h0);
    check_lit("wrap_fvalid", 64'(valid_out[0]), 64'h1);

    // Reset while stall and redirect are asserted
    step(1'b1, 1'b1, 32'h1234_5678, 1'b1);
    check_lit("rst_mid_f", 64'(stg(0)), 64'(RPC));
    check_lit("rst_mid_w", 64'(stg(4)), 64'(RPC));
    check_lit("rst_mid_cnt", 64'(redirect_cnt), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, rd, st;
      logic [31:0] tgt;
      r  = ($urandom_range(0, 99) == 0);
      rd = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r, rd, tgt, st);
    end

    // Redirect counter saturation
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 65534; i++) step(1'b0, 1'b1, 32'($urandom), 1'b0);
    check_lit("cnt_fffe", 64'(redirect_cnt), 64'hFFFE);
    step(1'b0, 1'b1, 32'h0100_0000, 1'b0);
    check_lit("cnt_ffff", 64'(redirect_cnt), 64'hFFFF);
    step(1'b0, 1'b1, 32'h0100_0000, 1'b0);
    step(1'b0, 1'b1, 32'h0100_0000, 1'b0);
    check_lit("cnt_sat", 64'(redirect_cnt), 64'hFFFF);
    run(2);

    @(negedge clock);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
